// File: rtl/muxpga_cfg_loader_if.sv
// Serial configuration stream into the muxpga loader.
// Master drives start/valid/bit; the loader is the slave.
interface muxpga_cfg_loader_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_bit;

  modport master (
    output cfg_start,
    output cfg_valid,
    output cfg_bit
  );

  modport slave (
    input cfg_start,
    input cfg_valid,
    input cfg_bit
  );
endinterface

// File: rtl/muxpga_cfg_loader.sv
// Serial bitstream loader: shadow shift, check, atomic commit to fabric.
// MUXPGA_CFG_PARITY_EN appends one even-parity bit to each load.
module muxpga_cfg_loader #(
  parameter int NUM_CELLS     = 12,
  parameter int CELL_CFG_BITS = 8
) (
  input  logic clk,
  input  logic reset_n,
  muxpga_cfg_loader_if.slave cfg,
  output logic [NUM_CELLS*CELL_CFG_BITS-1:0] cfg_active,
  output logic busy,
  output logic done,
  output logic err,
  output logic fabric_reset
);

  localparam int TOTAL = NUM_CELLS * CELL_CFG_BITS;
`ifdef MUXPGA_CFG_PARITY_EN
  localparam int NBITS = TOTAL + 1;
`else
  localparam int NBITS = TOTAL;
`endif
  localparam int CW = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    COMMIT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [TOTAL-1:0] shadow;
  logic             par_err;

`ifdef MUXPGA_CFG_PARITY_EN
  logic par_bit;

  // data parity xor the received bit must be even
  assign par_err = (^shadow) ^ par_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bit <= 1'b0;
    end else if (state == SHIFT && !cfg.cfg_start &&
                 cfg.cfg_valid && cnt == CW'(TOTAL)) begin
      par_bit <= cfg.cfg_bit;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shadow       <= '0;
      cfg_active   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      fabric_reset <= 1'b0;
    end else begin
      done         <= 1'b0;
      fabric_reset <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state <= SHIFT;
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cfg.cfg_start) begin
            cnt <= '0;
          end else if (cfg.cfg_valid) begin
            // first bit received drifts down to shadow[0]
            if (cnt < CW'(TOTAL)) begin
              shadow <= {cfg.cfg_bit, shadow[TOTAL-1:1]};
            end
            cnt <= cnt + ONE;
            if (cnt == LAST) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (cfg.cfg_start) begin
            state <= SHIFT;
            cnt   <= '0;
          end else if (par_err) begin
            state <= IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state        <= COMMIT;
            cfg_active   <= shadow;
            done         <= 1'b1;
            fabric_reset <= 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Directed bench for muxpga_cfg_loader: table of loads plus
// hand sequences for restart, reset abort and idle noise.
module tb_muxpga_cfg_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [95:0] cfg_active;
  logic        busy;
  logic        done;
  logic        err;
  logic        fabric_reset;

  muxpga_cfg_loader_if cfg();

  muxpga_cfg_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg          (cfg),
    .cfg_active   (cfg_active),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .fabric_reset (fabric_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [7:0]  pat;
    bit          tog;
    bit          flip;
    bit          sic;
    int          pre;
    logic [95:0] exp;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [95:0] hold;
  bit          stable_bad;
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic feed(input logic [7:0] b, input int n, input bit tog);
    int i = 0;
    int c = 0;
    while (i < n) begin
      cfg.cfg_valid = tog ? ~c[0] : 1'b1;
      cfg.cfg_bit   = b[i % 8];
      @(negedge clk);
      if (cfg.cfg_valid) i++;
      c++;
      if (cfg_active !== hold) stable_bad = 1'b1;
    end
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic send_parity(input logic [7:0] b, input bit flip);
`ifdef MUXPGA_CFG_PARITY_EN
    logic [95:0] dat;
    dat = {12{b}};
    cfg.cfg_valid = 1'b1;
    cfg.cfg_bit   = (^dat) ^ flip;
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    if (cfg_active !== hold) stable_bad = 1'b1;
`else
    cfg.cfg_valid = 1'b0;
    cfg.cfg_bit   = b[0] & flip;
`endif
  endtask

  task automatic do_load(input vec_t v);
    bit got;
    bit exp_err;
`ifdef MUXPGA_CFG_PARITY_EN
    exp_err = v.flip;
`else
    exp_err = 1'b0;
`endif
    hold       = cfg_active;
    stable_bad = 1'b0;
    cfg.cfg_start = 1'b1;
    @(negedge clk);
    cfg.cfg_start = 1'b0;
    chk({v.nm, "_busy"}, {95'd0, busy}, 96'd1);
    if (v.pre > 0) begin
      feed(8'h55, v.pre, 1'b0);
      // restart with valid high: start must win
      cfg.cfg_start = 1'b1;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_bit   = 1'b1;
      @(negedge clk);
      cfg.cfg_start = 1'b0;
      cfg.cfg_valid = 1'b0;
    end
    feed(v.pat, 96, v.tog);
    send_parity(v.pat, v.flip);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (done || err) got = 1'b1;
      else begin
        if (cfg_active !== hold) stable_bad = 1'b1;
        @(negedge clk);
      end
    end
    chk({v.nm, "_seen"}, {95'd0, got}, 96'd1);
    if (!exp_err) begin
      chk({v.nm, "_done"}, {95'd0, done}, 96'd1);
      chk({v.nm, "_frst"}, {95'd0, fabric_reset}, 96'd1);
      chk({v.nm, "_act"}, cfg_active, v.exp);
      chk({v.nm, "_hold"}, {95'd0, stable_bad}, 96'd0);
      if (v.sic) cfg.cfg_start = 1'b1;
      @(negedge clk);
      cfg.cfg_start = 1'b0;
      chk({v.nm, "_done0"}, {94'd0, done, fabric_reset}, 96'd0);
      chk({v.nm, "_idle"}, {94'd0, busy, err}, 96'd0);
    end else begin
      chk({v.nm, "_err"}, {94'd0, err, done}, 96'd2);
      chk({v.nm, "_keep"}, cfg_active, hold);
      chk({v.nm, "_idle"}, {95'd0, busy}, 96'd0);
    end
  endtask

  initial begin
    bit bad;
    reset_n       = 1'b0;
    cfg.cfg_start = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_bit   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_act", cfg_active, 96'd0);
    chk("rst_flags", {92'd0, busy, done, err, fabric_reset}, 96'd0);
    reset_n = 1'b1;
    @(negedge clk);

    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cfg.cfg_valid = 1'b1;
      cfg.cfg_bit   = k[0];
      @(negedge clk);
      if (busy || done || fabric_reset) bad = 1'b1;
    end
    cfg.cfg_valid = 1'b0;
    chk("idle_valid_ignored", {95'd0, bad}, 96'd0);
    chk("idle_act", cfg_active, 96'd0);

    tbl.push_back('{"a5", 8'hA5, 1'b0, 1'b0, 1'b0, 0, {12{8'hA5}}});
    tbl.push_back('{"a5_tog", 8'hA5, 1'b1, 1'b0, 1'b0, 0, {12{8'hA5}}});
    tbl.push_back('{"ff", 8'hFF, 1'b0, 1'b0, 1'b0, 0, {12{8'hFF}}});
    tbl.push_back('{"zero", 8'h00, 1'b0, 1'b0, 1'b0, 0, 96'd0});
    tbl.push_back('{"x81", 8'h81, 1'b0, 1'b0, 1'b0, 0, {12{8'h81}}});
    tbl.push_back('{"c3_sic", 8'hC3, 1'b1, 1'b0, 1'b1, 0, {12{8'hC3}}});
    tbl.push_back('{"abort3c", 8'h3C, 1'b0, 1'b0, 1'b0, 40, {12{8'h3C}}});
`ifdef MUXPGA_CFG_PARITY_EN
    tbl.push_back('{"par_bad", 8'h01, 1'b0, 1'b1, 1'b0, 0, 96'd0});
    tbl.push_back('{"par_ok", 8'h01, 1'b0, 1'b0, 1'b0, 0, {12{8'h01}}});
`endif
    tbl.push_back('{"ff2", 8'hFF, 1'b0, 1'b0, 1'b0, 0, {12{8'hFF}}});

    foreach (tbl[i]) do_load(tbl[i]);

    // abort a second load with reset after 50 bits
    hold = cfg_active;
    cfg.cfg_start = 1'b1;
    @(negedge clk);
    cfg.cfg_start = 1'b0;
    feed(8'h12, 50, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rstmid_act", cfg_active, 96'd0);
    chk("rstmid_flags", {92'd0, busy, done, err, fabric_reset}, 96'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 150; k++) begin
      cfg.cfg_valid = 1'b1;
      cfg.cfg_bit   = 1'($urandom_range(1));
      @(negedge clk);
      if (busy || done || fabric_reset) bad = 1'b1;
    end
    cfg.cfg_valid = 1'b0;
    chk("rstmid_no_commit", {95'd0, bad}, 96'd0);
    chk("rstmid_act_after", cfg_active, 96'd0);

    do_load('{"post_rst", 8'h96, 1'b0, 1'b0, 1'b0, 0, {12{8'h96}}});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muxpga_cfg_loader.md
MUXPGA_CFG_LOADER -- requirements
Module: muxpga_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 12, meaning number of configurable fabric cells (rows 1..4 x 3 cols).
REQ-002 SHALL have parameter CELL_CFG_BITS, default 8, meaning bits per cell: [3:0] input-mux select, [7:4] function cfg; TOTAL = NUM_CELLS*CELL_CFG_BITS (96).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start  input  1  begin a new load; sampled every cycle.
REQ-006 SHALL have port cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-007 SHALL have port cfg_bit  input  1  serial configuration data.
REQ-008 SHALL have port cfg_active  output  TOTAL  configuration driving the fabric; cell k occupies bits [k*8+7:k*8].
REQ-009 SHALL have port busy  output  1  high in SHIFT, CHECK and COMMIT.
REQ-010 SHALL have port done  output  1  one-cycle pulse on successful commit.
REQ-011 SHALL have port err  output  1  sticky load-error flag.
REQ-012 SHALL have port fabric_reset  output  1  one-cycle synchronous reset request to fabric cells.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, CHECK, COMMIT.
REQ-014 IDLE: cfg_start=1 -> SHIFT next cycle; bit counter cleared, err cleared, shadow register unchanged.
REQ-015 SHIFT: each cycle with cfg_valid=1, shadow shifts right one place, cfg_bit enters at bit TOTAL-1, counter increments; cfg_valid=0 holds shadow and counter.
REQ-016 Bit order: first bit received ends at shadow[0], last at shadow[TOTAL-1].
REQ-017 SHIFT: counter reaching TOTAL (on the accepting edge) -> CHECK next cycle.
REQ-018 cfg_start=1 in SHIFT or CHECK SHALL restart: counter cleared, state SHIFT, partially loaded bits discarded; cfg_start has priority over cfg_valid in the same cycle.
REQ-019 CHECK: with no error -> COMMIT; with error -> IDLE, err=1, cfg_active unchanged.
REQ-020 COMMIT (one cycle): cfg_active <= shadow, done=1, fabric_reset=1 during this cycle; then IDLE.
REQ-021 cfg_active SHALL change only on the COMMIT edge; fabric never observes partial configuration.
REQ-022 cfg_start in COMMIT SHALL be ignored; commit completes.
REQ-023 Counter width SHALL be clog2(TOTAL+2) bits; no wrap within a load.
REQ-024 cfg_valid in IDLE SHALL be ignored.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, counter 0, shadow 0, cfg_active 0, busy 0, done 0, err 0, fabric_reset 0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the load; no commit follows release.
REQ-027 All outputs SHALL be registered; cfg_active all-zero selects in1 = north neighbour, OR function.

Configuration
REQ-028 Macro MUXPGA_CFG_PARITY_EN defined: SHIFT expects TOTAL+1 bits; bit TOTAL+1 is an even-parity bit over all TOTAL data bits, held in a separate flop; CHECK flags error if parity of data XOR parity bit is 1.
REQ-029 Macro MUXPGA_CFG_PARITY_EN undefined: SHIFT expects exactly TOTAL bits, CHECK never flags error, err stays 0.

Verification
REQ-030 Reset, then load 96 bits of pattern 0xA5 repeated (first bit = LSB of byte 0) -> CHECK, COMMIT; done=1 one cycle; cfg_active = 96'hA5A5..A5; fabric_reset=1 same cycle.
REQ-031 Load with cfg_valid toggled 1/0 each cycle -> commit occurs after 96 accepted bits (~192 cycles); same cfg_active as contiguous load.
REQ-032 Start load, send 40 bits, assert cfg_start, send full 96-bit pattern 0x3C -> cfg_active = all 0x3C; bits from aborted load absent.
REQ-033 Load 0xFF, then send 50 bits of a second load, pull reset_n low -> cfg_active=0, busy=0 immediately; after release no done pulse without new cfg_start.
REQ-034 With MUXPGA_CFG_PARITY_EN: 96 bits of 0x01 plus parity bit 1 (wrong; 12 ones = even, expect 0) -> err=1, done never asserted, cfg_active retains previous value; correct parity 0 -> commit.
REQ-035 While busy, check cfg_active constant every cycle until COMMIT edge.
